mac_accum: RTL and testbench
============================

Name: mac_accum

Overview:
- Downstream consumer of the per-lane 2-bit x 2-bit multipliers. Each accepted beat carries LANES signed 4-bit products, and the block adds them together through an adder tree.
- The block accumulates beat sums across a frame, which is a dot-product segment terminated by in_last, using a saturating accumulator.
- At the end of a frame it presents the sum, the beat count and an overflow flag on a valid/ready output register for the activation/writeback stage.

Parameters:
- LANES, 4, number of 4-bit product lanes per beat (power of 2, 1..16).
- ACC_W, 12, accumulator and result width in bits (signed, two's complement, >= 4+log2(LANES)).
- CNT_W, 8, beat-counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  beat present on in_prod/in_last.
- in_ready  out  1  block can accept a beat this cycle.
- in_prod  in  4*LANES  lane i at bits [4i+3:4i], signed 4-bit product (legal multiplier range -6..+3; full -8..+7 must be handled).
- in_last  in  1  accepted beat is the final beat of the frame.
- out_valid  out  1  result register holds a completed frame.
- out_ready  in  1  downstream takes the result this cycle.
- out_sum  out  ACC_W  signed saturated frame sum.
- out_cnt  out  CNT_W  beats in frame, saturating at 2^CNT_W-1.
- out_ovf  out  1  sticky: accumulator saturated at least once during the frame.

Behaviour:
- Reset (async, immediate): acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0; state=ACCUM. A reset mid-frame discards the partial frame and any held result.
- Handshakes:
  - accept = in_valid && in_ready.
  - take = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to in_ready.
  - out_* remain stable while out_valid && !out_ready.
- Lane sum: each lane is sign-extended, then all lanes are summed combinationally into a (4+log2 LANES)-bit lane_sum, which is then sign-extended to ACC_W+1 bits.
- Saturating add:
  - nxt = acc + lane_sum, computed at ACC_W+1 bits.
  - If nxt > 2^(ACC_W-1)-1, clamp to the maximum and set sat=1. If nxt < -2^(ACC_W-1), clamp to the minimum and set sat=1.
  - Clamped values persist: later beats add to the clamped value.
- States: ACCUM and HOLD. HOLD is implied by out_valid=1; accumulation of the next frame may proceed in parallel with HOLD.
- On accept with in_last=0:
  - acc <= sat_nxt.
  - cnt <= cnt+1 (saturating).
  - ovf <= ovf|sat.
- On accept with in_last=1:
  - out_sum <= sat_nxt.
  - out_cnt <= cnt+1 (saturating).
  - out_ovf <= ovf|sat.
  - out_valid <= 1.
  - acc, cnt and ovf are cleared to 0 for the next frame.
  - Latency: result visible the cycle after the last beat is accepted.
- Simultaneous take and last-accept: out_* are loaded with the new frame and out_valid stays 1. This gives full throughput with back-to-back single-beat frames.
- Take without a last-accept: out_valid <= 0. out_sum, out_cnt and out_ovf keep their old values; they are don't-care for the bench.
- in_valid=0: no state change in the accumulator.
- Single-beat frame (in_last on the first beat): out_cnt=1, out_sum=lane_sum.
- Blocked output: when out_valid=1 and out_ready=0, in_ready=0. The upstream stage stalls, and no beat is lost or duplicated.

Test Plan:
- Reset, then LANES=4: 3 beats of {+3,+3,+3,+3} with in_last on beat 3 and out_ready=1 -> out_valid one cycle after beat 3; out_sum=36, out_cnt=3, out_ovf=0.
- Mixed signs: beats {-6,+3,-1,0} then {+2,-2,+1,-6} (last) -> out_sum=-9, out_cnt=2.
- Positive saturation, ACC_W=6: 3 beats of {+3,+3,+3,+3} -> after beat 3, out_sum=+31 and out_ovf=1. A following frame of 1 beat {1,0,0,0} -> out_sum=1, out_ovf=0.
- Negative saturation with recovery, ACC_W=6:
  - Stimulus: 2 beats of {-6,-6,-6,-6}, clamped at -32, then {+3,+3,+3,+3} (last).
  - Required response: out_sum=-20, out_ovf=1.
- Backpressure: hold out_ready=0 after frame A completes while in_valid stays high -> in_ready=0 and out_* stable for 5 cycles. Then raise out_ready with frame B as a single-beat frame -> out_* load B the same cycle A is taken.
- Reset mid-frame: accept 2 beats, pulse rst -> all outputs 0 immediately. A new frame {1,1,1,1} (last) -> out_sum=4, out_cnt=1.

Source files
------------

// File: rtl/mac_accum.sv
// mac_accum: adds LANES signed 4-bit products per beat, accumulates beat sums
// with saturation across a frame, and delivers each frame result on a valid/ready register.
module mac_accum #(
    parameter int LANES = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*LANES-1:0]      in_prod,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_ovf
);
    localparam int LSW = 4 + $clog2(LANES);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
    logic                    out_ovf_q, out_ovf_d;

    logic signed [LSW-1:0]   lane_sum_s;
    logic signed [ACC_W:0]   lane_ext_s;
    logic signed [ACC_W:0]   acc_ext_s;
    logic signed [ACC_W:0]   nxt_s;
    logic signed [ACC_W-1:0] sat_nxt_s;
    logic                    sat_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    logic                    accept_s;
    logic                    take_s;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign take_s    = out_valid && out_ready;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    // Adder tree: sign-extend every lane to the lane-sum width and add.
    always_comb begin
        lane_sum_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum_s = lane_sum_s + LSW'($signed(in_prod[4*i +: 4]));
        end
    end

    // Saturating add at one guard bit; the top two bits disagree only on overflow.
    always_comb begin
        lane_ext_s = (ACC_W+1)'(lane_sum_s);
        acc_ext_s  = {acc_q[ACC_W-1], acc_q};
        nxt_s      = acc_ext_s + lane_ext_s;
        if (nxt_s[ACC_W] != nxt_s[ACC_W-1]) begin
            sat_s     = 1'b1;
            sat_nxt_s = nxt_s[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_s     = 1'b0;
            sat_nxt_s = nxt_s[ACC_W-1:0];
        end
        if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_W'(1);
        end
    end

    // Next-state: accumulate, close a frame into the output register, or release it.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        state_d   = state_q;
        if (accept_s && in_last) begin
            out_sum_d = sat_nxt_s;
            out_cnt_d = cnt_inc_s;
            out_ovf_d = ovf_q | sat_s;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            state_d   = HOLD;
        end else if (accept_s) begin
            acc_d = sat_nxt_s;
            cnt_d = cnt_inc_s;
            ovf_d = ovf_q | sat_s;
            case (take_s)
                1'b1:    state_d = ACCUM;
                default: state_d = state_q;
            endcase
        end else if (take_s) begin
            state_d = ACCUM;
        end else begin
            state_d = state_q;
        end
    end

    // State registers with immediate reset discarding any partial or held frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end
endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum: a 12-bit and a 6-bit accumulator instance share
// stimulus lines; frames are routed to one instance at a time by sel.
module tb_mac_accum;
    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_prod = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        sel = 1'b0;

    logic        iv12, rdy12, ov12, ovf12;
    logic [11:0] sum12;
    logic [7:0]  cnt12;
    logic        iv6, rdy6, ov6, ovf6;
    logic [5:0]  sum6;
    logic [7:0]  cnt6;

    int checks = 0;
    int failures = 0;
    exp_t q12[$];
    exp_t q6[$];

    assign iv12 = in_valid && !sel;
    assign iv6  = in_valid && sel;

    always #5 clk = ~clk;

    mac_accum #(.LANES(4), .ACC_W(12), .CNT_W(8)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(rdy12), .in_prod(in_prod),
        .in_last(in_last), .out_valid(ov12), .out_ready(out_ready),
        .out_sum(sum12), .out_cnt(cnt12), .out_ovf(ovf12));

    mac_accum #(.LANES(4), .ACC_W(6), .CNT_W(8)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(rdy6), .in_prod(in_prod),
        .in_last(in_last), .out_valid(ov6), .out_ready(out_ready),
        .out_sum(sum6), .out_cnt(cnt6), .out_ovf(ovf6));

    function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
        logic [3:0] la, lb, lc, ld;
        la = 4'(a); lb = 4'(b); lc = 4'(c); ld = 4'(d);
        return {ld, lc, lb, la};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input bit w6, input int s, input int c, input bit o);
        exp_t e;
        e.sum = s; e.cnt = c; e.ovf = o;
        if (w6) q6.push_back(e);
        else    q12.push_back(e);
    endtask

    // Issue one beat on the selected instance and return just after it is accepted.
    task automatic send(input logic [15:0] p, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_prod = p; in_last = last;
        @(negedge clk);
        while (!(sel ? rdy6 : rdy12) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Monitor for the 12-bit instance: compare each taken result with the queue head.
    always @(negedge clk) begin
        if (!rst && ov12 && out_ready) begin
            if (q12.size() == 0) begin
                chk("w12_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q12.pop_front();
                chk("w12_sum", int'($signed(sum12)), e.sum);
                chk("w12_cnt", int'(cnt12), e.cnt);
                chk("w12_ovf", int'(ovf12), int'(e.ovf));
            end
        end
    end

    // Monitor for the 6-bit instance.
    always @(negedge clk) begin
        if (!rst && ov6 && out_ready) begin
            if (q6.size() == 0) begin
                chk("w6_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q6.pop_front();
                chk("w6_sum", int'($signed(sum6)), e.sum);
                chk("w6_cnt", int'(cnt6), e.cnt);
                chk("w6_ovf", int'(ovf6), int'(e.ovf));
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(ov12), 0);
        chk("rst_out_sum", int'(sum12), 0);
        chk("rst_out_cnt", int'(cnt12), 0);
        chk("rst_in_ready", int'(rdy12), 1);
        chk("rst6_out_valid", int'(ov6), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Three beats of +3 on every lane: 36 with result one cycle after the last beat.
        push(1'b0, 36, 3, 1'b0);
        send(pk(3, 3, 3, 3), 1'b0);
        send(pk(3, 3, 3, 3), 1'b0);
        chk("pre_last_out_valid", int'(ov12), 0);
        send(pk(3, 3, 3, 3), 1'b1);
        chk("latency_out_valid", int'(ov12), 1);

        // Mixed signs: -4 then -5.
        push(1'b0, -9, 2, 1'b0);
        send(pk(-6, 3, -1, 0), 1'b0);
        send(pk(2, -2, 1, -6), 1'b1);

        // Full 4-bit lane range: +28 then -32.
        push(1'b0, -4, 2, 1'b0);
        send(pk(7, 7, 7, 7), 1'b0);
        send(pk(-8, -8, -8, -8), 1'b1);

        // 6-bit instance: positive clamp, then a clean frame with ovf cleared.
        sel = 1'b1;
        push(1'b1, 31, 3, 1'b1);
        send(pk(3, 3, 3, 3), 1'b0);
        send(pk(3, 3, 3, 3), 1'b0);
        send(pk(3, 3, 3, 3), 1'b1);
        push(1'b1, 1, 1, 1'b0);
        send(pk(1, 0, 0, 0), 1'b1);

        // Negative clamp at -32, then recovery by +12.
        push(1'b1, -20, 3, 1'b1);
        send(pk(-6, -6, -6, -6), 1'b0);
        send(pk(-6, -6, -6, -6), 1'b0);
        send(pk(3, 3, 3, 3), 1'b1);
        sel = 1'b0;

        // Backpressure: frame A held while frame B waits at the input.
        out_ready = 1'b0;
        push(1'b0, 8, 1, 1'b0);
        send(pk(2, 2, 2, 2), 1'b1);
        push(1'b0, -4, 1, 1'b0);
        in_valid = 1'b1; in_prod = pk(-1, -1, -1, -1); in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(rdy12), 0);
            chk("bp_out_valid", int'(ov12), 1);
            chk("bp_out_sum", int'($signed(sum12)), 8);
            chk("bp_out_cnt", int'(cnt12), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_b_loaded_valid", int'(ov12), 1);
        chk("bp_b_loaded_sum", int'($signed(sum12)), -4);
        @(negedge clk);

        // Reset mid-frame discards two accepted beats and the stale result.
        send(pk(1, 1, 1, 1), 1'b0);
        send(pk(1, 1, 1, 1), 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(ov12), 0);
        chk("midrst_out_sum", int'(sum12), 0);
        chk("midrst_out_cnt", int'(cnt12), 0);
        chk("midrst_out_ovf", int'(ovf12), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1'b0, 4, 1, 1'b0);
        send(pk(1, 1, 1, 1), 1'b1);

        n = 0;
        while ((q12.size() != 0 || q6.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", q12.size() + q6.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
